relay_sequencer: RTL and testbench

//  Sequences the board relay bank from a DSP-written target pattern: one relay changes per step,

---
 rtl/relay_sequencer.sv | 118 +++++++++++
 tb/tb_relay_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/relay_sequencer.sv
// Relay bank sequencer: walks the relay outputs toward a DSP-written target one bit per step,
// openings first, with a fixed settle time after every change; any fault opens everything at once.
module relay_sequencer #(
  parameter int N_RELAY       = 8,
  parameter int SETTLE_CYCLES = 2000000,
  parameter int CNT_W         = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               cmd_wr_i,
  input  logic [N_RELAY-1:0] cmd_data_i,
  input  logic               fault_i,
  input  logic               fault_clr_i,
  output logic [N_RELAY-1:0] relay_o,
  output logic [N_RELAY-1:0] target_o,
  output logic               busy_o,
  output logic               fault_latched_o,
  output logic               cmd_rej_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_RELAY-1:0] relay_q, relay_d;
  logic [N_RELAY-1:0] target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               faultLatched_q, faultLatched_d;
  logic               cmdRej_q, cmdRej_d;

  logic [N_RELAY-1:0] openMask, closeMask;
  logic [N_RELAY-1:0] openLow, closeLow, stepMask;

  // Lowest pending opening wins; a closing is only taken once nothing is left to open.
  always_comb begin
    openMask  = relay_q & ~target_q;
    closeMask = ~relay_q & target_q;
    openLow   = openMask & (~openMask + N_RELAY'(1));
    closeLow  = closeMask & (~closeMask + N_RELAY'(1));
    stepMask  = (openMask != '0) ? openLow : closeLow;
  end

  always_comb begin
    state_d        = state_q;
    relay_d        = relay_q;
    target_d       = target_q;
    cnt_d          = cnt_q;
    faultLatched_d = faultLatched_q;
    cmdRej_d       = 1'b0;

    if (fault_i) begin
      state_d        = FAULT;
      relay_d        = '0;
      target_d       = '0;
      cnt_d          = '0;
      faultLatched_d = 1'b1;
      cmdRej_d       = cmd_wr_i;
    end else begin
      unique case (state_q)
        FAULT: begin
          cmdRej_d = cmd_wr_i;
          if (fault_clr_i) begin
            state_d        = IDLE;
            faultLatched_d = 1'b0;
          end
        end
        IDLE: begin
          if (cmd_wr_i) target_d = cmd_data_i;
          // The step is chosen from the target held before this edge, giving one cycle of latency.
          if (relay_q != target_q) begin
            relay_d = relay_q ^ stepMask;
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (cmd_wr_i) target_d = cmd_data_i;
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != FAULT) && ((state_d == SETTLE) || (relay_d != target_d));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= IDLE;
      relay_q        <= '0;
      target_q       <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      faultLatched_q <= 1'b0;
      cmdRej_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      relay_q        <= relay_d;
      target_q       <= target_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      faultLatched_q <= faultLatched_d;
      cmdRej_q       <= cmdRej_d;
    end
  end

  assign relay_o         = relay_q;
  assign target_o        = target_q;
  assign busy_o          = busy_q;
  assign fault_latched_o = faultLatched_q;
  assign cmd_rej_o       = cmdRej_q;

endmodule

// File: tb/tb_relay_sequencer.sv
// Self-checking bench for relay_sequencer with a short settle time: hand sequences for the
// multi-cycle stepping cases plus a vector table for fault, reject and reset behaviour.
module tb_relay_sequencer;

  localparam int N_RELAY       = 8;
  localparam int SETTLE_CYCLES = 10;
  localparam int CNT_W         = 8;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               cmdWr;
  logic [N_RELAY-1:0] cmdData;
  logic               fault;
  logic               faultClr;
  logic [N_RELAY-1:0] relay;
  logic [N_RELAY-1:0] target;
  logic               busy;
  logic               faultLatched;
  logic               cmdRej;

  int checks   = 0;
  int failures = 0;

  relay_sequencer #(
    .N_RELAY      (N_RELAY),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .cmd_wr_i       (cmdWr),
    .cmd_data_i     (cmdData),
    .fault_i        (fault),
    .fault_clr_i    (faultClr),
    .relay_o        (relay),
    .target_o       (target),
    .busy_o         (busy),
    .fault_latched_o(faultLatched),
    .cmd_rej_o      (cmdRej)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] data;
    logic       flt;
    logic       clr;
    logic [7:0] expRelay;
    logic [7:0] expTarget;
    logic       expBusy;
    logic       expFault;
    logic       expRej;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic wr, input logic [7:0] data,
                               input logic flt, input logic clr);
    @(negedge CLK);
    RESET    = rst;
    cmdWr    = wr;
    cmdData  = data;
    fault    = flt;
    faultClr = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic checkAll(input string name, input logic [7:0] r, input logic [7:0] t,
                          input logic b, input logic f, input logic j);
    checkOutput({name, " relay"}, 32'(relay), 32'(r));
    checkOutput({name, " target"}, 32'(target), 32'(t));
    checkOutput({name, " busy"}, 32'(busy), 32'(b));
    checkOutput({name, " fault_latched"}, 32'(faultLatched), 32'(f));
    checkOutput({name, " cmd_rej"}, 32'(cmdRej), 32'(j));
  endtask

  // Steps idle cycles until relay moves away from prev, then checks the new value and the spacing.
  task automatic measureChange(input logic [7:0] prev, input logic [7:0] expVal,
                               input int expGap, input string name);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 40) begin
      idleCycles(1);
      n++;
      if (relay !== prev) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: relay stuck at 0x%0h expected change to 0x%0h", name, relay, expVal);
    end else begin
      checkOutput({name, " value"}, 32'(relay), 32'(expVal));
      checkOutput({name, " gap"}, 32'(n), 32'(expGap));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] order[7];
    logic [7:0] prev;

    RESET = 1'b1; cmdWr = 1'b0; cmdData = '0; fault = 1'b0; faultClr = 1'b0;

    // Reset state, then 0x05 steps in as 0x01 then 0x05, 11 cycles apart.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkAll("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
    checkAll("wr05", 8'h00, 8'h05, 1'b1, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("wr05 first step", 32'(relay), 32'h01);
    measureChange(8'h01, 8'h05, 11, "wr05 second step");
    for (int k = 1; k <= 10; k++) begin
      idleCycles(1);
      checkOutput($sformatf("wr05 busy tail %0d", k), 32'(busy), (k < 10) ? 32'd1 : 32'd0);
    end

    // Openings before closings, lowest index first.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
    idleCycles(60);
    checkAll("settled0F", 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("order step0", 32'(relay), 32'h0E);
    order = '{8'h0C, 8'h08, 8'h00, 8'h10, 8'h30, 8'h70, 8'hF0};
    prev = 8'h0E;
    for (int i = 0; i < 7; i++) begin
      measureChange(prev, order[i], 11, $sformatf("order step%0d", i + 1));
      prev = order[i];
    end
    idleCycles(11);
    checkAll("settledF0", 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0);

    // Reverting the bit just moved waits for the settle to finish.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("revert first step", 32'(relay), 32'h01);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checkAll("revert wr", 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    measureChange(8'h01, 8'h00, 8, "revert open");
    idleCycles(11);
    checkOutput("revert busy end", 32'(busy), 32'd0);

    // Reset in the middle of a settle opens everything and nothing resumes.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h07, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("rst07 step1", 32'(relay), 32'h01);
    measureChange(8'h01, 8'h03, 11, "rst07 step2");
    measureChange(8'h03, 8'h07, 11, "rst07 step3");
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkAll("rst07 reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    idleCycles(15);
    checkAll("rst07 after", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Single-cycle vectors: fault, reject, clear and reset priority.
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 8'h80, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].flt, vecs[i].clr);
      checkAll($sformatf("vec%0d", i), vecs[i].expRelay, vecs[i].expTarget,
               vecs[i].expBusy, vecs[i].expFault, vecs[i].expRej);
    end

    // Fault while fully closed opens all relays in one edge.
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    idleCycles(100);
    checkAll("closedFF", 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkAll("faultFF", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idleCycles(2);
    checkAll("faultFF cleared", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
